// File: rtl/btn_conditioner.sv
// Per-channel button front end: two-flop synchroniser, stability-count debouncer, press/release strobes.
// Optional auto-repeat on held buttons is built when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int unsigned NUM_BTN              = 3,
    parameter int unsigned DEBOUNCE_CYCLES      = 120000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 6000000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 1200000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_param_check
        $error("btn_conditioner: illegal parameter value");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } rpt_state_e;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             level_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             rise;
        logic             fall;

        // Any cycle of agreement with the current level restarts the stability count.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            rise    = 1'b0;
            fall    = 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_d = sync2_q;
                    rise    = sync2_q;
                    fall    = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        rpt_state_e       state_q;
        rpt_state_e       state_d;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic [RPT_W-1:0] rpt_cnt_d;
        logic             rpt_fire;

        // Release is checked first so it always beats a coincident repeat strobe.
        always_comb begin
            state_d   = state_q;
            rpt_cnt_d = rpt_cnt_q;
            rpt_fire  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    rpt_cnt_d = '0;
                    if (rise) begin
                        state_d = HELD_DELAY;
                    end
                end
                HELD_DELAY: begin
                    if (fall) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == DELAY_LAST) begin
                        state_d   = HELD_REPEAT;
                        rpt_cnt_d = '0;
                        rpt_fire  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                HELD_REPEAT: begin
                    if (fall) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        rpt_cnt_d = '0;
                        rpt_fire  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q   <= IDLE;
                rpt_cnt_q <= '0;
            end else begin
                state_q   <= state_d;
                rpt_cnt_q <= rpt_cnt_d;
            end
        end

        assign press_d = rise | rpt_fire;
`else
        assign press_d = rise;
`endif

        assign release_d = fall;

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= btn_raw[i];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3.
// Expected auto-repeat strobes follow BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

    logic       CLK;
    logic       RST;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;

    int unsigned n_checks;
    int unsigned n_errors;

    btn_conditioner #(
        .NUM_BTN              (3),
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (10),
        .REPEAT_PERIOD_CYCLES (3)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                              input logic [2:0] rel);
        check_eq({tag, " level"},   btn_level,   lvl);
        check_eq({tag, " press"},   btn_press,   prs);
        check_eq({tag, " release"}, btn_release, rel);
    endtask

    // Channel 0 press strobes when held from edge 0 and released at edge 20 (release lands at 25).
    function automatic logic [2:0] press_hold_exp(input int e);
`ifdef BTN_AUTOREPEAT_EN
        if (e == 5 || e == 15 || e == 18 || e == 21 || e == 24) return 3'b001;
`else
        if (e == 5) return 3'b001;
`endif
        return 3'b000;
    endfunction

    logic [7:0] glitch_pat;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        RST        = 1'b1;
        btn_raw    = 3'b000;
        glitch_pat = 8'b0111_0111;

        for (int k = 0; k < 3; k++) begin
            step();
            check_outs($sformatf("reset c%0d", k), 3'b000, 3'b000, 3'b000);
        end
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_outs($sformatf("idle c%0d", k), 3'b000, 3'b000, 3'b000);
        end

        // Clean press, hold, release on channel 0 (also covers auto-repeat timing).
        btn_raw = 3'b001;
        for (int e = 0; e <= 30; e++) begin
            step();
            check_outs($sformatf("hold e%0d", e),
                       (e >= 5 && e < 25) ? 3'b001 : 3'b000,
                       press_hold_exp(e),
                       (e == 25) ? 3'b001 : 3'b000);
            if (e == 19) btn_raw = 3'b000;
        end

        // Glitch on channel 1: three synchronised ones are one short of the debounce count.
        for (int k = 0; k < 8; k++) begin
            btn_raw[1] = glitch_pat[k];
            step();
            check_outs($sformatf("glitch k%0d", k), 3'b000, 3'b000, 3'b000);
        end
        btn_raw = 3'b000;
        for (int k = 0; k < 6; k++) begin
            step();
            check_outs($sformatf("glitch tail k%0d", k), 3'b000, 3'b000, 3'b000);
        end

        // All channels together.
        btn_raw = 3'b111;
        for (int e = 0; e <= 8; e++) begin
            step();
            check_outs($sformatf("simul e%0d", e),
                       (e >= 5) ? 3'b111 : 3'b000,
                       (e == 5) ? 3'b111 : 3'b000,
                       3'b000);
        end

        // Reset while held: outputs clear, then a fresh press with no release.
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_outs($sformatf("midrst c%0d", k), 3'b000, 3'b000, 3'b000);
        end
        RST = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            step();
            check_outs($sformatf("postrst e%0d", e),
                       (e >= 5) ? 3'b111 : 3'b000,
                       (e == 5) ? 3'b111 : 3'b000,
                       3'b000);
        end

        // Simultaneous release; lands before any repeat would fire.
        btn_raw = 3'b000;
        for (int e = 0; e <= 8; e++) begin
            step();
            check_outs($sformatf("relall e%0d", e),
                       (e >= 5) ? 3'b000 : 3'b111,
                       3'b000,
                       (e == 5) ? 3'b111 : 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
